stereolbm_deadlock_scan_ctrl: RTL

//  Round-robin scheduler over the per-process HLS deadlock monitors of the stereo LBM core.

---
 rtl/stereolbm_deadlock_scan_ctrl_if.sv | 25 ++
 rtl/stereolbm_deadlock_scan_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/stereolbm_deadlock_scan_ctrl_if.sv
// Report channel between the deadlock scan controller and its consumer (status block).
// The master raises report_valid and holds idx/time stable until report_ready is seen.
interface stereolbm_deadlock_scan_ctrl_if #(
  parameter int IDX_W = 3,
  parameter int CNT_W = 16
);
  logic             report_valid;
  logic             report_ready;
  logic [IDX_W-1:0] report_idx;
  logic [CNT_W-1:0] report_time;

  modport master (
    output report_valid,
    output report_idx,
    output report_time,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_idx,
    input  report_time,
    output report_ready
  );
endinterface

// File: rtl/stereolbm_deadlock_scan_ctrl.sv
// Round-robin scanner over HLS deadlock monitor block flags; confirms persistence, reports once per episode.
// Optional macro DEADLOCK_TIMESTAMP_EN adds a free-running cycle stamp captured at confirmation.
module stereolbm_deadlock_scan_ctrl #(
  parameter int NUM_MON = 8,
  parameter int IDX_W   = 3,
  parameter int THRESH  = 16,
  parameter int CNT_W   = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [NUM_MON-1:0]            mon_block,
  stereolbm_deadlock_scan_ctrl_if.master rpt,
  output logic                          any_deadlock,
  output logic [NUM_MON-1:0]            deadlock_mask,
  output logic                          scan_busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DWELL,
    ST_REPORT,
    ST_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(THRESH - 1);
  localparam logic [IDX_W-1:0] PTR_LAST   = IDX_W'(NUM_MON - 1);

  state_t               state_q, state_d;
  logic [NUM_MON-1:0]   mon_q;
  logic [NUM_MON-1:0]   mask_q, mask_d;
  logic                 any_q, any_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     cand_q, cand_d;
  logic [CNT_W-1:0]     dwell_q, dwell_d;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + IDX_W'(1);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mon_q   <= '0;
      mask_q  <= '0;
      any_q   <= 1'b0;
      ptr_q   <= '0;
      cand_q  <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      mon_q   <= mon_block;
      mask_q  <= mask_d;
      any_q   <= any_d;
      ptr_q   <= ptr_d;
      cand_q  <= cand_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cand_d  = cand_q;
    dwell_d = dwell_q;
    mask_d  = mask_q;
    any_d   = any_q;

    // Clear applies first so a same-cycle acceptance below re-sets its own bit.
    if (clear) begin
      mask_d = '0;
      any_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_SCAN;
      end

      ST_SCAN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          dwell_d = '0;
        end else if (mon_q[ptr_q]) begin
          state_d = ST_DWELL;
          cand_d  = ptr_q;
          dwell_d = CNT_W'(1);
        end else begin
          ptr_d = wrap_inc(ptr_q);
        end
      end

      ST_DWELL: begin
        if (!enable) begin
          state_d = ST_IDLE;
          dwell_d = '0;
        end else if (mon_q[cand_q]) begin
          if (dwell_q == DWELL_LAST) state_d = ST_REPORT;
          if (dwell_q != '1) dwell_d = dwell_q + CNT_W'(1);
        end else begin
          // Short glitch: resume scanning just past the rejected candidate.
          state_d = ST_SCAN;
          ptr_d   = wrap_inc(cand_q);
          dwell_d = '0;
        end
      end

      ST_REPORT: begin
        if (rpt.report_ready) begin
          mask_d[cand_q] = 1'b1;
          any_d          = 1'b1;
          dwell_d        = '0;
          state_d        = enable ? ST_HOLD : ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (!enable) begin
          state_d = ST_IDLE;
          dwell_d = '0;
        end else if (!mon_q[cand_q]) begin
          state_d = ST_SCAN;
          ptr_d   = wrap_inc(cand_q);
        end
      end

      default: begin
        state_d = ST_IDLE;
        dwell_d = '0;
      end
    endcase
  end

  assign rpt.report_valid = (state_q == ST_REPORT);
  assign rpt.report_idx   = cand_q;
  assign any_deadlock     = any_q;
  assign deadlock_mask    = mask_q;
  assign scan_busy        = (state_q != ST_IDLE);

`ifdef DEADLOCK_TIMESTAMP_EN
  logic [CNT_W-1:0] stamp_q;
  logic [CNT_W-1:0] rtime_q;
  logic             confirm;

  assign confirm = (state_q == ST_DWELL) && (state_d == ST_REPORT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stamp_q <= '0;
      rtime_q <= '0;
    end else begin
      stamp_q <= stamp_q + CNT_W'(1);
      if (confirm) rtime_q <= stamp_q;
    end
  end

  assign rpt.report_time = rtime_q;
`else
  assign rpt.report_time = '0;
`endif

endmodule
